// File: rtl/uart_tx_fifo_reader.sv
// 8N1 UART transmitter that drains a first-word-fall-through FIFO, one byte per frame,
// sending frames back to back with no idle gap while data is available and enabled.
module uart_tx_fifo_reader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DATA_BITS-1:0] fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_deq,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRELAST = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST   = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_r;
    logic [CW-1:0]          cnt_r;
    logic [BW-1:0]          bit_idx_r;
    logic                   stop_idx_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   tx_r;
    logic                   busy_r;
    logic                   frame_done_r;

    logic                   go_s;
    logic                   bit_end_s;
    logic                   stop_last_s;
    logic                   pop_s;
    logic [DATA_BITS-1:0]   shift_nx_s;

    assign go_s        = en & ~fifo_empty;
    assign bit_end_s   = (cnt_r == CNT_LAST);
    assign stop_last_s = (state_r == STOP) && bit_end_s && (stop_idx_r == STOP_LAST);
    assign shift_nx_s  = shift_r >> 1;

    // Pop decision: a new frame may only start from IDLE or on the very last stop cycle.
    always_comb begin
        pop_s = 1'b0;
        if (rst) begin
            pop_s = 1'b0;
        end else if (go_s && ((state_r == IDLE) || stop_last_s)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign fifo_deq   = pop_s;
    assign tx         = tx_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

    // Frame sequencer with registered line, busy and end-of-frame outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= '0;
            stop_idx_r   <= 1'b0;
            shift_r      <= '0;
            tx_r         <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (pop_s) begin
                        state_r <= START;
                        shift_r <= fifo_dout;
                        tx_r    <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        cnt_r     <= '0;
                        bit_idx_r <= '0;
                        state_r   <= DATA;
                        tx_r      <= shift_r[0];
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        cnt_r   <= '0;
                        shift_r <= shift_nx_s;
                        if (bit_idx_r == BIT_LAST) begin
                            state_r    <= STOP;
                            stop_idx_r <= 1'b0;
                            tx_r       <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + BW'(1);
                            tx_r      <= shift_nx_s[0];
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                STOP: begin
                    // Raised one cycle early so the registered pulse lines up with the final stop cycle.
                    frame_done_r <= (cnt_r == CNT_PRELAST) && (stop_idx_r == STOP_LAST);
                    if (bit_end_s) begin
                        cnt_r <= '0;
                        if (stop_idx_r == STOP_LAST) begin
                            if (pop_s) begin
                                state_r <= START;
                                shift_r <= fifo_dout;
                                tx_r    <= 1'b0;
                                busy_r  <= 1'b1;
                            end else begin
                                state_r <= IDLE;
                                tx_r    <= 1'b1;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            stop_idx_r <= stop_idx_r + 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: FIFO model plus line decoder feeding a byte scoreboard,
// with one task per scenario checking cycle-exact waveforms.
module tb_uart_tx_fifo_reader;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] en;
    logic [1:0] fifo_empty;
    logic [1:0] fifo_deq;
    logic [1:0] tx;
    logic [1:0] busy;
    logic [1:0] frame_done;
    logic [7:0] fifo_dout [2];

    logic [7:0] fq [2][$];
    logic [7:0] sb [2][$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .en(en[0]), .fifo_dout(fifo_dout[0]), .fifo_empty(fifo_empty[0]),
        .fifo_deq(fifo_deq[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0])
    );

    uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .en(en[1]), .fifo_dout(fifo_dout[1]), .fifo_empty(fifo_empty[1]),
        .fifo_deq(fifo_deq[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1])
    );

    function automatic void refresh();
        for (int g = 0; g < 2; g++) begin
            fifo_empty[g] = (fq[g].size() == 0);
            fifo_dout[g]  = (fq[g].size() != 0) ? fq[g][0] : 8'h00;
        end
    endfunction

    // FIFO model: pop on the edge where fifo_deq was high, then update head/flag.
    logic [1:0] deq_smp;
    logic [1:0] empty_smp;
    always @(posedge clk) begin
        deq_smp   = fifo_deq;
        empty_smp = fifo_empty;
        #1;
        for (int g = 0; g < 2; g++) begin
            if (deq_smp[g] === 1'b1) begin
                n_tests++;
                if (empty_smp[g] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL deq_when_empty ch%0d: fifo_empty=%b required 0", g, empty_smp[g]);
                end else begin
                    void'(fq[g].pop_front());
                end
            end
        end
        refresh();
    end

    // Line decoder: rebuilds each frame, checks busy/frame_done timing and scores the byte.
    int         mcnt [2];
    bit         mact [2];
    logic [7:0] mbyte [2];
    logic [7:0] exp_b;
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int flen;
            flen = CPB * (10 + g);
            if (rst === 1'b1) begin
                mact[g] = 1'b0;
            end else begin
                if (!mact[g] && tx[g] === 1'b0) begin
                    mact[g] = 1'b1;
                    mcnt[g] = 0;
                end else if (mact[g]) begin
                    mcnt[g]++;
                end
                if (mact[g]) begin
                    if (mcnt[g] >= CPB + 1 && mcnt[g] <= CPB * 8 + 1 && ((mcnt[g] - 1) % CPB) == 0)
                        mbyte[g][(mcnt[g] - 1) / CPB - 1] = tx[g];
                    n_tests++;
                    if (frame_done[g] !== (mcnt[g] == flen - 1)) begin
                        n_fail++;
                        $display("FAIL frame_done ch%0d cyc%0d: got %b required %b", g, mcnt[g] + 1,
                                 frame_done[g], (mcnt[g] == flen - 1));
                    end
                    n_tests++;
                    if (busy[g] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL busy_in_frame ch%0d cyc%0d: got %b required 1", g, mcnt[g] + 1, busy[g]);
                    end
                    if (mcnt[g] == flen - 1) begin
                        mact[g] = 1'b0;
                        n_tests++;
                        if (sb[g].size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_frame ch%0d: got %h required none", g, mbyte[g]);
                        end else begin
                            exp_b = sb[g].pop_front();
                            if (mbyte[g] !== exp_b) begin
                                n_fail++;
                                $display("FAIL rx_byte ch%0d: got %h required %h", g, mbyte[g], exp_b);
                            end
                        end
                    end
                end else begin
                    n_tests++;
                    if (frame_done[g] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL frame_done_idle ch%0d: got %b required 0", g, frame_done[g]);
                    end
                end
            end
        end
    end

    task automatic at_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int g, input logic [7:0] b, input bit scored);
        fq[g].push_back(b);
        if (scored) sb[g].push_back(b);
        refresh();
    endtask

    task automatic wait_deq(input int g, input int maxc, output int waited);
        waited = -1;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (fifo_deq[g] === 1'b1) begin
                waited = c;
                break;
            end
        end
    endtask

    task automatic check_pop(input int g, input int maxc, input string name);
        int w;
        wait_deq(g, maxc, w);
        n_tests++;
        if (w !== 0) begin
            n_fail++;
            $display("FAIL %s: pop delay %0d required 0", name, w);
        end
    endtask

    // Checks tx every cycle of one frame after the pop cycle; optionally drops en at cycle drop_at.
    task automatic frame_check(input int g, input logic [7:0] b, input int drop_at, input logic last_deq);
        int   flen;
        logic e;
        flen = CPB * (10 + g);
        for (int i = 0; i < flen; i++) begin
            @(negedge clk);
            if (i < CPB) e = 1'b0;
            else if (i < CPB * 9) e = b[(i - CPB) / CPB];
            else e = 1'b1;
            n_tests++;
            if (tx[g] !== e) begin
                n_fail++;
                $display("FAIL tx_level ch%0d byte %h cyc%0d: got %b required %b", g, b, i + 1, tx[g], e);
            end
            n_tests++;
            if (fifo_deq[g] !== ((i == flen - 1) ? last_deq : 1'b0)) begin
                n_fail++;
                $display("FAIL deq_in_frame ch%0d cyc%0d: got %b required %b", g, i + 1, fifo_deq[g],
                         (i == flen - 1) ? last_deq : 1'b0);
            end
            if (i == drop_at) en[g] = 1'b0;
        end
    endtask

    task automatic test_reset();
        at_drive();
        en = 2'b01;
        push(0, 8'h55, 1'b1);
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (tx !== 2'b11 || busy !== 2'b00 || frame_done !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_state: tx=%b busy=%b done=%b required 11 00 00", tx, busy, frame_done);
            end
            n_tests++;
            if (fifo_deq !== 2'b00) begin
                n_fail++;
                $display("FAIL deq_during_rst: got %b required 00", fifo_deq);
            end
        end
        at_drive();
        en  = 2'b00;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (fifo_deq[0] !== 1'b0 || tx[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle: deq=%b tx=%b required 0 1", fifo_deq[0], tx[0]);
        end
    endtask

    task automatic test_basic();
        at_drive();
        en[0] = 1'b1;
        check_pop(0, 4, "basic_pop");
        frame_check(0, 8'h55, -1, 1'b0);
        @(negedge clk);
        n_tests++;
        if (busy[0] !== 1'b0 || tx[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_after: busy=%b tx=%b required 0 1", busy[0], tx[0]);
        end
    endtask

    task automatic test_back_to_back();
        at_drive();
        push(0, 8'hA3, 1'b1);
        push(0, 8'h0F, 1'b1);
        check_pop(0, 4, "b2b_pop1");
        frame_check(0, 8'hA3, -1, 1'b1);
        frame_check(0, 8'h0F, -1, 1'b0);
        @(negedge clk);
        n_tests++;
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_after: busy=%b required 0", busy[0]);
        end
    endtask

    task automatic test_en_gate();
        int bad;
        bad = 0;
        at_drive();
        en[0] = 1'b0;
        push(0, 8'h3C, 1'b1);
        repeat (100) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || fifo_deq[0] !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL en_gate: %0d active cycles required 0", bad);
        end
        at_drive();
        en[0] = 1'b1;
        check_pop(0, 1, "en_gate_pop");
        frame_check(0, 8'h3C, -1, 1'b0);
    endtask

    task automatic test_en_drop();
        int bad;
        bad = 0;
        at_drive();
        en[0] = 1'b0;
        push(0, 8'hFF, 1'b1);
        push(0, 8'h81, 1'b0);
        at_drive();
        en[0] = 1'b1;
        check_pop(0, 4, "en_drop_pop");
        frame_check(0, 8'hFF, 12, 1'b0);
        repeat (20) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || fifo_deq[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0 || fq[0].size() != 1) begin
            n_fail++;
            $display("FAIL en_drop_idle: %0d bad cycles, fifo level %0d required 0, 1", bad, fq[0].size());
        end
        at_drive();
        fq[0].delete();
        refresh();
    endtask

    task automatic test_reset_midframe();
        at_drive();
        push(0, 8'h96, 1'b0);
        push(0, 8'h5A, 1'b1);
        at_drive();
        en[0] = 1'b1;
        check_pop(0, 4, "rstmid_pop");
        repeat (17) @(negedge clk);
        n_tests++;
        if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_bit3: tx=%b busy=%b required 0 1", tx[0], busy[0]);
        end
        at_drive();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (fifo_deq[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_deq_in_rst: got %b required 0", fifo_deq[0]);
        end
        at_drive();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || fifo_deq[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_after: tx=%b busy=%b deq=%b required 1 0 1", tx[0], busy[0], fifo_deq[0]);
        end
        frame_check(0, 8'h5A, -1, 1'b0);
        @(negedge clk);
        n_tests++;
        if (fq[0].size() != 0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_end: fifo level %0d busy=%b required 0 0", fq[0].size(), busy[0]);
        end
    endtask

    task automatic test_two_stop();
        at_drive();
        en[1] = 1'b1;
        push(1, 8'h00, 1'b1);
        check_pop(1, 2, "two_stop_pop");
        frame_check(1, 8'h00, -1, 1'b0);
        @(negedge clk);
        n_tests++;
        if (busy[1] !== 1'b0 || tx[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL two_stop_after: busy=%b tx=%b required 0 1", busy[1], tx[1]);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 2'b00;
        refresh();
        test_reset();
        test_basic();
        test_back_to_back();
        test_en_gate();
        test_en_drop();
        test_reset_midframe();
        test_two_stop();
        repeat (3) @(negedge clk);
        n_tests++;
        if (sb[0].size() != 0 || sb[1].size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d/%0d bytes left required 0/0", sb[0].size(), sb[1].size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
